// File: rtl/naval_game_sequencer_if.sv
// Control/datapath bundle for the naval game sequencer.
// master: player controls + map/hit datapath side; slave: the sequencer.
interface naval_game_sequencer_if;
  logic       start;
  logic       confirm;
  logic [2:0] map_code;
  logic [2:0] x_coord;
  logic [2:0] y_coord;
  logic       cell_is_ship;
  logic       cell_already_hit;
  logic [1:0] game_state_code;
  logic [2:0] saved_map_code;
  logic       hit_wr_en;
  logic [5:0] hit_addr;
  logic [1:0] led_rgb;
  logic [5:0] hits_count;
  logic [4:0] shots_used;
  logic       win;

  modport master (
    output start, confirm, map_code, x_coord, y_coord, cell_is_ship, cell_already_hit,
    input  game_state_code, saved_map_code, hit_wr_en, hit_addr, led_rgb,
           hits_count, shots_used, win
  );

  modport slave (
    input  start, confirm, map_code, x_coord, y_coord, cell_is_ship, cell_already_hit,
    output game_state_code, saved_map_code, hit_wr_en, hit_addr, led_rgb,
           hits_count, shots_used, win
  );
endinterface

// File: rtl/naval_game_sequencer.sv
// Naval-battle round sequencer: IDLE -> PREP -> ATTACK/CHECK/HOLD -> END.
// Shot effects (strobe, counters, LED) are registered on the confirm edge so
// they are visible during the single CHECK cycle; HOLD stretches the LED.
// Optional feature macro: SHOT_LIMIT_EN (ends the game without a win once
// MAX_SHOTS shots have been accepted).
module naval_game_sequencer #(
  parameter int COLS       = 7,
  parameter int ROWS       = 5,
  parameter int SHIP_CELLS = 8,
  parameter int MAX_SHOTS  = 15,
  parameter int LED_HOLD   = 4    // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  naval_game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ATTACK, S_CHECK, S_HOLD, S_END} state_t;

`ifdef SHOT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int            HW        = (LED_HOLD > 2) ? $clog2(LED_HOLD) : 1;
  // CHECK already shows the LED for one cycle, HOLD covers the rest.
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LED_HOLD - 2);

  state_t        state;
  logic          shot_ok;    // registered shot had in-range coordinates
  logic [HW-1:0] hold_cnt;
  logic          coord_ok;
  logic [5:0]    addr;
  logic          won;
  logic          budget_out;

  assign coord_ok   = (int'(bus.x_coord) < COLS) && (int'(bus.y_coord) < ROWS);
  assign addr       = 6'(int'(bus.y_coord) * COLS + int'(bus.x_coord));
  assign won        = (bus.hits_count == 6'(SHIP_CELLS));
  assign budget_out = LIMIT_EN && (int'(bus.shots_used) >= MAX_SHOTS);

  // Round FSM with all outputs registered; start low always returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      shot_ok             <= 1'b0;
      hold_cnt            <= '0;
      bus.game_state_code <= 2'b00;
      bus.saved_map_code  <= 3'd0;
      bus.hit_wr_en       <= 1'b0;
      bus.hit_addr        <= 6'd0;
      bus.led_rgb         <= 2'b00;
      bus.hits_count      <= 6'd0;
      bus.shots_used      <= 5'd0;
      bus.win             <= 1'b0;
    end else begin
      bus.hit_wr_en <= 1'b0;
      if (!bus.start) begin
        // start fall beats any confirm; pending strobe is dropped
        state               <= S_IDLE;
        bus.game_state_code <= 2'b00;
        bus.saved_map_code  <= 3'd0;
        bus.led_rgb         <= 2'b00;
        bus.hits_count      <= 6'd0;
        bus.shots_used      <= 5'd0;
        bus.win             <= 1'b0;
        shot_ok             <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state               <= S_PREP;
            bus.game_state_code <= 2'b01;
          end
          S_PREP: begin
            bus.saved_map_code <= bus.map_code;
            if (bus.confirm && bus.map_code <= 3'd4) begin
              state               <= S_ATTACK;
              bus.game_state_code <= 2'b10;
              bus.hits_count      <= 6'd0;
              bus.shots_used      <= 5'd0;
            end
          end
          S_ATTACK: begin
            if (bus.confirm) begin
              state        <= S_CHECK;
              bus.hit_addr <= addr;
              shot_ok      <= coord_ok;
              if (!coord_ok) begin
                bus.led_rgb <= 2'b00;
              end else if (bus.cell_already_hit) begin
                bus.led_rgb <= 2'b01;
              end else begin
                bus.hit_wr_en <= 1'b1;
                if (bus.shots_used != 5'd31)
                  bus.shots_used <= bus.shots_used + 5'd1;
                if (bus.cell_is_ship && bus.hits_count < 6'(SHIP_CELLS))
                  bus.hits_count <= bus.hits_count + 6'd1;
                bus.led_rgb <= bus.cell_is_ship ? 2'b10 : 2'b01;
              end
            end
          end
          S_CHECK: begin
            if (!shot_ok) begin
              state <= S_ATTACK;
            end else begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              bus.led_rgb <= 2'b00;
              if (won) begin
                state               <= S_END;
                bus.game_state_code <= 2'b11;
                bus.win             <= 1'b1;
              end else if (budget_out) begin
                state               <= S_END;
                bus.game_state_code <= 2'b11;
              end else begin
                state <= S_ATTACK;
              end
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          S_END: begin
            // frozen until start falls
          end
          default: begin
            state               <= S_IDLE;
            bus.game_state_code <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_naval_game_sequencer.sv
// Directed bench for naval_game_sequencer: prep/map latch, hits, repeats,
// out-of-range shots, win, shot budget, start-fall priority, async reset.
module tb_naval_game_sequencer;
  logic clk = 1'b0;
  logic reset;
  naval_game_sequencer_if bus();

  naval_game_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start from IDLE with start low; ends at a negedge in ATTACK
  task automatic new_game(input int map);
    bus.start    = 1'b1;
    bus.map_code = 3'(map);
    nclk(1);
    bus.confirm = 1'b1;
    nclk(1);
    bus.confirm = 1'b0;
  endtask

  // fire from ATTACK at a negedge; checks CHECK-cycle outputs and LED hold
  task automatic shot(input string tag, input int x, input int y, input int ship,
                      input int already, input int we, input int addr,
                      input int hits, input int shots, input int led);
    bus.x_coord          = 3'(x);
    bus.y_coord          = 3'(y);
    bus.cell_is_ship     = ship[0];
    bus.cell_already_hit = already[0];
    bus.confirm          = 1'b1;
    nclk(1);
    bus.confirm = 1'b0;
    chk({tag, ".we"}, int'(bus.hit_wr_en), we);
    if (we != 0) chk({tag, ".addr"}, int'(bus.hit_addr), addr);
    chk({tag, ".hits"}, int'(bus.hits_count), hits);
    chk({tag, ".shots"}, int'(bus.shots_used), shots);
    chk({tag, ".led"}, int'(bus.led_rgb), led);
    if (led != 0) begin
      nclk(3);
      chk({tag, ".led_hold"}, int'(bus.led_rgb), led);
      nclk(1);
      chk({tag, ".led_off"}, int'(bus.led_rgb), 0);
    end else begin
      nclk(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.confirm = 1'b0; bus.map_code = 3'd0;
    bus.x_coord = 3'd0; bus.y_coord = 3'd0;
    bus.cell_is_ship = 1'b0; bus.cell_already_hit = 1'b0;
    nclk(2);
    chk("rst.state", int'(bus.game_state_code), 0);
    chk("rst.saved", int'(bus.saved_map_code), 0);
    chk("rst.we", int'(bus.hit_wr_en), 0);
    chk("rst.addr", int'(bus.hit_addr), 0);
    chk("rst.led", int'(bus.led_rgb), 0);
    chk("rst.hits", int'(bus.hits_count), 0);
    chk("rst.shots", int'(bus.shots_used), 0);
    chk("rst.win", int'(bus.win), 0);
    reset = 1'b0;
    nclk(1);
    chk("idle.hold", int'(bus.game_state_code), 0);

    // prep: invalid map ignored, then map 3 latched
    bus.start = 1'b1; bus.map_code = 3'd5;
    nclk(1);
    chk("prep.state", int'(bus.game_state_code), 1);
    bus.confirm = 1'b1;
    nclk(1);
    chk("prep.bad_map", int'(bus.game_state_code), 1);
    chk("prep.pass", int'(bus.saved_map_code), 5);
    bus.map_code = 3'd3;
    nclk(1);
    bus.confirm = 1'b0;
    chk("prep.to_attack", int'(bus.game_state_code), 2);
    chk("prep.saved", int'(bus.saved_map_code), 3);
    bus.map_code = 3'd6;
    nclk(1);
    chk("attack.saved_frozen", int'(bus.saved_map_code), 3);

    // shots
    shot("hit21", 2, 1, 1, 0, 1, 9, 1, 1, 2);
    chk("hit21.state", int'(bus.game_state_code), 2);
    shot("rehit", 2, 1, 1, 1, 0, 0, 1, 1, 1);
    shot("x7", 7, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("x7.state", int'(bus.game_state_code), 2);
    shot("y5", 0, 5, 1, 0, 0, 0, 1, 1, 0);
    shot("corner", 6, 4, 0, 0, 1, 34, 1, 2, 1);
    shot("origin", 0, 0, 0, 0, 1, 0, 1, 3, 1);
    for (int i = 0; i < 7; i++) begin
      shot("row2", i, 2, 1, 0, 1, 14 + i, 2 + i, 4 + i, 2);
      chk("row2.state", int'(bus.game_state_code), (i == 6) ? 3 : 2);
      chk("row2.win", int'(bus.win), (i == 6) ? 1 : 0);
    end
    // END ignores confirm
    bus.x_coord = 3'd1; bus.y_coord = 3'd1; bus.cell_is_ship = 1'b0;
    bus.confirm = 1'b1;
    nclk(1);
    bus.confirm = 1'b0;
    nclk(1);
    chk("end.frozen_shots", int'(bus.shots_used), 10);
    chk("end.state", int'(bus.game_state_code), 3);
    bus.start = 1'b0;
    nclk(1);
    chk("end2idle.state", int'(bus.game_state_code), 0);
    chk("end2idle.hits", int'(bus.hits_count), 0);
    chk("end2idle.shots", int'(bus.shots_used), 0);
    chk("end2idle.win", int'(bus.win), 0);

    // shot budget
    new_game(2);
    chk("g2.state", int'(bus.game_state_code), 2);
    chk("g2.saved", int'(bus.saved_map_code), 2);
    for (int i = 0; i < 15; i++)
      shot("miss", 0, 0, 0, 0, 1, 0, 0, i + 1, 1);
`ifdef SHOT_LIMIT_EN
    chk("limit.state", int'(bus.game_state_code), 3);
    chk("limit.win", int'(bus.win), 0);
`else
    chk("nolimit.state", int'(bus.game_state_code), 2);
    shot("shot16", 3, 3, 0, 0, 1, 24, 0, 16, 1);
    chk("shot16.state", int'(bus.game_state_code), 2);
`endif
    bus.start = 1'b0;
    nclk(1);

    // start fall wins over a simultaneous confirm
    new_game(1);
    bus.start = 1'b0; bus.confirm = 1'b1;
    bus.x_coord = 3'd1; bus.y_coord = 3'd0; bus.cell_is_ship = 1'b1;
    bus.cell_already_hit = 1'b0;
    nclk(1);
    bus.confirm = 1'b0;
    chk("fall.state", int'(bus.game_state_code), 0);
    chk("fall.we", int'(bus.hit_wr_en), 0);
    chk("fall.shots", int'(bus.shots_used), 0);

    // async reset in the middle of CHECK
    new_game(4);
    bus.x_coord = 3'd2; bus.y_coord = 3'd1; bus.cell_is_ship = 1'b1;
    bus.confirm = 1'b1;
    @(posedge clk);
    #1 bus.confirm = 1'b0;
    chk("pre_rst.we", int'(bus.hit_wr_en), 1);
    #1 reset = 1'b1;
    #1;
    chk("async.state", int'(bus.game_state_code), 0);
    chk("async.we", int'(bus.hit_wr_en), 0);
    chk("async.hits", int'(bus.hits_count), 0);
    chk("async.led", int'(bus.led_rgb), 0);
    chk("async.saved", int'(bus.saved_map_code), 0);
    bus.start = 1'b0;
    nclk(1);
    reset = 1'b0;
    nclk(1);
    chk("post_rst.state", int'(bus.game_state_code), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
